md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit controller for the EX stage, placed beside the ALU. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO command per start pulse and sequences multi-cycle operations with a down-counter. HI/LO are committed only when the operation completes. It drives `busy` so the hazard unit can stall later multiply/divide-class instructions.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU in cycles (≥1)
- DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles (≥1)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
- B  input  32  operand rt (divisor / multiplier)
- op  input  3  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0 and 7 are no-op
- start  input  1  command valid this cycle (EX-stage instruction is MD-class)
- busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- State: IDLE (count==0) and RUN (count!=0). Internal regs: count (4 bits), pend_hi/pend_lo (32 bits each), pend_we (1 bit).
- Reset: HI=0, LO=0, count=0, busy=0, pend_we=0.
- IDLE, start=1, op MULT/MULTU:
  - Compute the 64-bit product, signed or unsigned as selected.
  - pend_hi=prod[63:32], pend_lo=prod[31:0], pend_we=1, count=MULT_CYCLES.
- IDLE, start=1, op DIV/DIVU:
  - pend_lo=quotient, pend_hi=remainder, count=DIV_CYCLES.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - B==0: pend_we=0. The counter still runs the full DIV_CYCLES and HI/LO stay unchanged.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- IDLE, start=1, op MTHI: HI=A at that edge. MTLO: LO=A at that edge. count stays 0 and busy stays 0.
- IDLE, start=1, op 0 or 7: no state change.
- RUN: count decrements each cycle.
  - On the edge where count goes 1→0: if pend_we, HI=pend_hi and LO=pend_lo. pend_we is cleared.
- RUN, start=1: the command is ignored entirely, including MTHI/MTLO. The hazard unit guarantees this does not happen; the block must not corrupt state if it does.
- busy = (count != 0), driven from a register, not combinationally from start.
- Reset during RUN aborts: count=0, pend_we=0, HI=LO=0 at that edge. The pending result is discarded.

## Timing
- Start accepted at edge E0 → busy=1 for exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES (cycles E0..E0+N−1 after the edges).
- HI/LO take their new value at edge E0+N, the same edge busy falls. Back-to-back start is accepted at E0+N.
- MTHI/MTLO latency is one edge. Values are visible in the cycle after the start edge, and busy never asserts.
- Operands are sampled only at the start edge. Changes to A/B/op during RUN have no effect.
- HI/LO outputs hold their old values throughout RUN.
- reset has priority over start at the same edge.

## Test plan
- MULT: A=0xFFFFFFFE (−2), B=3, start 1 cycle → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. HI/LO unchanged while busy.
- MULTU: A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV: A=−7 (0xFFFFFFF9), B=2 → busy 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU: A=7, B=0 with prior HI=0x11, LO=0x22 → busy 10 cycles; HI/LO remain 0x11/0x22.
- MTHI A=0x1234 while idle → HI=0x1234 next cycle, busy=0. Then MULT start, and MTLO A=0x5555 issued at cycle 2 of RUN → MTLO ignored; LO = product low after 5 cycles.
- Start DIV, assert reset at cycle 4 of RUN → next cycle busy=0, HI=LO=0. No late write-back occurs at cycle 10.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide controller with a down-counted busy window and deferred HI/LO commit
//   clk   : clock, all state updates on rising edge
//   reset : synchronous active-high, clears all state and aborts a running operation
//   A, B  : operands rs / rt, sampled only at the accepting edge
//   op    : 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 0/7 no-op
//   start : command valid this cycle
//   busy  : registered, high while an operation is in flight
//   HI, LO: architectural HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [3:0] MC = 4'(MULT_CYCLES);
    localparam logic [3:0] DC = 4'(DIV_CYCLES);

    logic [3:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d, busy_q;
    logic        is_mul, is_div, sx, neg_a, neg_b;
    logic [63:0] prod;
    logic [31:0] mag_a, mag_b, div_b, uq, ur, quo, rem;

    assign is_mul = (op == 3'd1) || (op == 3'd2);
    assign is_div = (op == 3'd3) || (op == 3'd4);
    assign sx     = (op == 3'd1) || (op == 3'd3);
    // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
    assign prod   = {{32{sx & A[31]}}, A} * {{32{sx & B[31]}}, B};
    // Signed divide works on magnitudes, then restores signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 wraps back to 0x80000000 naturally.
    assign neg_a  = sx & A[31];
    assign neg_b  = sx & B[31];
    assign mag_a  = neg_a ? -A : A;
    assign mag_b  = neg_b ? -B : B;
    assign div_b  = (B == 32'd0) ? 32'd1 : mag_b;
    assign uq     = mag_a / div_b;
    assign ur     = mag_a % div_b;
    assign quo    = (neg_a ^ neg_b) ? -uq : uq;
    assign rem    = neg_a ? -ur : ur;

    always_comb begin
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        if (count_q == 4'd0) begin
            if (start && is_mul) begin
                pend_hi_d = prod[63:32];
                pend_lo_d = prod[31:0];
                pend_we_d = 1'b1;
                count_d   = MC;
            end else if (start && is_div) begin
                pend_hi_d = rem;
                pend_lo_d = quo;
                pend_we_d = (B != 32'd0);
                count_d   = DC;
            end
            hi_d = (start && op == 3'd5) ? A : hi_q;
            lo_d = (start && op == 3'd6) ? A : lo_q;
        end else begin
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) begin
                hi_d      = pend_we_q ? pend_hi_q : hi_q;
                lo_d      = pend_we_q ? pend_lo_q : lo_q;
                pend_we_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
            busy_q    <= (count_d != 4'd0);
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit with directed vectors
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic [2:0]  op = '0;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] HI, LO;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
        .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] ohi, olo, nhi, nlo;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, failures = 0;
    logic        probe = 1'b0;
    logic        busy_prev = 1'b0;
    int          run_cnt = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, req);
        end
    endtask

    // Monitor: pops an expectation whenever busy falls (operation done) or a probe is raised.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            run_cnt++;
            if (sb.size() > 0) begin
                check({sb[0].name, "_hold_hi"}, HI, sb[0].ohi);
                check({sb[0].name, "_hold_lo"}, LO, sb[0].olo);
            end
        end
        if (busy_prev && busy !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done: got busy fall expected none");
            end else begin
                e = sb.pop_front();
                check({e.name, "_cycles"}, 32'(run_cnt), 32'(e.cyc));
                check({e.name, "_hi"}, HI, e.nhi);
                check({e.name, "_lo"}, LO, e.nlo);
            end
            run_cnt = 0;
        end
        if (probe) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_probe: got probe expected none");
            end else begin
                e = sb.pop_front();
                check({e.name, "_busy"}, {31'd0, busy}, 32'd0);
                check({e.name, "_hi"}, HI, e.nhi);
                check({e.name, "_lo"}, LO, e.nlo);
            end
        end
        busy_prev = (busy === 1'b1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input int c, input logic [31:0] nh, input logic [31:0] nl);
        exp_t e;
        e.name = n; e.cyc = c; e.ohi = exp_hi; e.olo = exp_lo; e.nhi = nh; e.nlo = nl;
        sb.push_back(e);
        exp_hi = nh;
        exp_lo = nl;
    endtask

    task automatic do_probe(input string n);
        push(n, 0, exp_hi, exp_lo);
        probe = 1'b1;
        @(negedge clk);
        #1 probe = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        cyc();
        start = 1'b0; op = 3'd0;
    endtask

    // mode 1: MTLO attempted in RUN cycle 2; mode 2: reset in RUN cycle 4
    task automatic run_op(input string n, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int c, input logic [31:0] nh,
                          input logic [31:0] nl, input int mode);
        int k;
        push(n, c, nh, nl);
        issue(o, a, b);
        if (mode == 1) begin
            cyc();
            start = 1'b1; op = 3'd6; A = 32'h5555; B = 32'h7;
            cyc();
            start = 1'b0; op = 3'd0; A = 32'hDEAD_BEEF;
        end else if (mode == 2) begin
            repeat (3) cyc();
            reset = 1'b1;
            cyc();
            reset = 1'b0;
        end else begin
            A = ~a; B = ~b;
        end
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            cyc();
            k++;
        end
        if (k >= 40) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got busy stuck expected release", n);
        end
        cyc();
    endtask

    task automatic mt(input string n, input logic [2:0] o, input logic [31:0] a);
        issue(o, a, 32'h0);
        if (o == 3'd5) exp_hi = a; else exp_lo = a;
        do_probe(n);
    endtask

    initial begin
        repeat (2) cyc();
        reset = 1'b0;
        do_probe("reset");
        run_op("mult",     3'd1, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_op("multu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("div",      3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        mt("mthi11", 3'd5, 32'h11);
        mt("mtlo22", 3'd6, 32'h22);
        run_op("divu_z",   3'd4, 32'd7,         32'd0,        10, 32'h11,        32'h22,        0);
        run_op("div_ovf",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0,        32'h8000_0000, 0);
        run_op("div_pos",  3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,        32'hFFFF_FFFD, 0);
        run_op("divu",     3'd4, 32'd100,       32'd7,        10, 32'd2,         32'd14,        0);
        mt("mthi1234", 3'd5, 32'h1234);
        run_op("mult_ign", 3'd1, 32'd3,         32'd5,        5,  32'd0,         32'd15,        1);
        run_op("div_abort",3'd3, 32'd50,        32'd3,        4,  32'd0,         32'd0,         2);
        repeat (12) cyc();
        do_probe("no_late_wb");
        op = 3'd7; start = 1'b1; A = 32'hABCD;
        cyc();
        start = 1'b0;
        do_probe("noop7");
        repeat (3) cyc();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
endmodule
